// File: rtl/sumador_q22_pkg.sv
// Shared widths, saturation limit and operand/sum types for the Q3.2 adder.
package sumador_q22_pkg;

    localparam int unsigned OPW   = 5;
    localparam int unsigned SUMW  = 6;
    localparam int unsigned FRACW = 2;

    localparam logic [SUMW-1:0] SAT_MAX = 6'd31;

    typedef logic [OPW-1:0]  opnd_t;
    typedef logic [SUMW-1:0] sum_t;

endpackage

// File: rtl/sumador_q22_fa.sv
// One-bit full adder cell used to build the ripple-carry operand adder.
module sumador_q22_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    logic w_p;

    assign w_p    = i_a ^ i_b;
    assign o_s    = w_p ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule

// File: rtl/sumador_q22.sv
// Unsigned Q3.2 + Q3.2 -> Q4.2 adder with a sticky overflow flag.
// Define SUMADORQ22_SAT_EN to clamp the sum output to 31 on overflow.
module sumador_q22
    import sumador_q22_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    opnd_t          w_a;
    opnd_t          w_b;
    logic [OPW:0]   w_carry;
    opnd_t          w_bits;
    sum_t           w_sum;
    sum_t           w_sum_out;
    logic           w_ovf;
    logic           w_unused;
    logic           r_sticky;

    assign w_a = ui_in[OPW-1:0];
    assign w_b = uio_in[OPW-1:0];

    assign w_carry[0] = 1'b0;

    for (genvar gi = 0; gi < OPW; gi++) begin : g_ripple
        sumador_q22_fa u_fa (
            .i_a    (w_a[gi]),
            .i_b    (w_b[gi]),
            .i_cin  (w_carry[gi]),
            .o_s    (w_bits[gi]),
            .o_cout (w_carry[gi+1])
        );
    end

    // Final carry-out is the Q4.2 integer MSB and doubles as the overflow bit.
    assign w_sum = {w_carry[OPW], w_bits};
    assign w_ovf = w_sum[SUMW-1];

`ifdef SUMADORQ22_SAT_EN
    assign w_sum_out = w_ovf ? SAT_MAX : w_sum;
`else
    assign w_sum_out = w_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (ena && w_ovf) begin
            r_sticky <= 1'b1;
        end
    end

    assign uo_out  = {r_sticky, w_ovf, w_sum_out};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    assign w_unused = &{ui_in[7:OPW], uio_in[7:OPW], 1'b0};

endmodule

// File: tb/tb_sumador_q22.sv
// Directed and exhaustive bench for sumador_q22 with a cycle-by-cycle model check.
module tb_sumador_q22;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b0;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_total = 0;
    int n_pass  = 0;
    logic m_sticky = 1'b0;

    sumador_q22 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    function automatic int true_sum(input logic [7:0] a, input logic [7:0] b);
        return int'(a[4:0]) + int'(b[4:0]);
    endfunction

    function automatic int shown_sum(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = true_sum(a, b);
`ifdef SUMADORQ22_SAT_EN
        if (s > 31) s = 31;
`endif
        return s;
    endfunction

    function automatic int lit_sum(input int exact);
`ifdef SUMADORQ22_SAT_EN
        return (exact > 31) ? 31 : exact;
`else
        return exact;
`endif
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Sticky behaviour from the rules: set on an enabled edge with sum > 31, async clear.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_sticky = 1'b0;
        else if (ena && true_sum(ui_in, uio_in) > 31) m_sticky = 1'b1;
    end

    always @(negedge clk) begin
        check("cyc_sum",    int'(uo_out[5:0]), shown_sum(ui_in, uio_in));
        check("cyc_ovf",    int'(uo_out[6]),   (true_sum(ui_in, uio_in) > 31) ? 1 : 0);
        check("cyc_sticky", int'(uo_out[7]),   int'(m_sticky));
        check("cyc_uio",    int'({uio_oe, uio_out}), 0);
    end

    task automatic drive(input int a, input int b);
        @(negedge clk);
        #2;
        ui_in  = {ui_in[7:5],  a[4:0]};
        uio_in = {uio_in[7:5], b[4:0]};
        #1;
    endtask

    initial begin
        // Reset asserted: sum path live, sticky and tie-offs zero.
        ui_in = 8'd3; uio_in = 8'd5;
        #1;
        check("rst_sticky",  int'(uo_out[7]),   0);
        check("rst_sum",     int'(uo_out[5:0]), 8);
        check("rst_uio_out", int'(uio_out),     0);
        check("rst_uio_oe",  int'(uio_oe),      0);
        @(negedge clk); #2; rst_n = 1'b1;

        drive(3, 5);
        check("t1_sum",    int'(uo_out[5:0]), 8);
        check("t1_ovf",    int'(uo_out[6]),   0);
        check("t1_sticky", int'(uo_out[7]),   0);

        ena = 1'b1;
        drive(31, 31);
        check("t2_sum",    int'(uo_out[5:0]), lit_sum(62));
        check("t2_ovf",    int'(uo_out[6]),   1);
        check("t2_pre",    int'(uo_out[7]),   0);
        @(posedge clk); #1;
        check("t2_sticky", int'(uo_out[7]),   1);

        drive(0, 0);
        check("t3_sum",    int'(uo_out[5:0]), 0);
        check("t3_ovf",    int'(uo_out[6]),   0);
        check("t3_hold",   int'(uo_out[7]),   1);
        rst_n = 1'b0; #1;
        check("t3_async",  int'(uo_out[7]),   0);
        rst_n = 1'b1;

        ena = 1'b0;
        drive(16, 16);
        check("t4_sum",    int'(uo_out[5:0]), lit_sum(32));
        check("t4_ovf",    int'(uo_out[6]),   1);
        repeat (3) @(posedge clk);
        #1;
        check("t4_noena",  int'(uo_out[7]),   0);

        drive(16, 15);
        check("b_31_sum",  int'(uo_out[5:0]), 31);
        check("b_31_ovf",  int'(uo_out[6]),   0);

        // Reset released while overflowing: first enabled edge sets the flag.
        @(negedge clk); #2; rst_n = 1'b0; ena = 1'b1;
        ui_in = 8'd16; uio_in = 8'd16;
        @(negedge clk); #2; rst_n = 1'b1; #1;
        check("rel_pre",   int'(uo_out[7]),   0);
        @(posedge clk); #1;
        check("rel_set",   int'(uo_out[7]),   1);

        @(negedge clk); #2; rst_n = 1'b0; #1; rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                @(negedge clk); #2;
                ui_in  = {3'($urandom_range(7)), a[4:0]};
                uio_in = {3'($urandom_range(7)), b[4:0]};
                #1;
                check("sweep_sum", int'(uo_out[5:0]), lit_sum(a + b));
            end
        end

        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
